pipe_ctrl: RTL

Parametrised pipeline stall/flush controller for the MIPS core; the successor to the fixed two-request, six-bit stall generator. It takes one stall request per pipeline stage and produces a thermometer stall mask. It also runs a flush state machine that turns an exception request into a one-cycle pipeline flush plus a redirect PC. An optional watchdog flags stalls that never release.

---
 rtl/pipe_ctrl_if.sv | 32 +++
 rtl/pipe_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stall requests and exception inputs in, stall mask and flush/redirect out.
// The stall_timeout signal exists only when PIPE_CTRL_WATCHDOG_EN is defined.
interface pipe_ctrl_if #(
  parameter int NUM_STAGES = 6,
  parameter int PC_W       = 32
);
  logic [NUM_STAGES-1:0] stallreq;
  logic                  exc_req;
  logic [PC_W-1:0]       exc_pc;
  logic [NUM_STAGES-1:0] stall;
  logic                  flush;
  logic [PC_W-1:0]       new_pc;
`ifdef PIPE_CTRL_WATCHDOG_EN
  logic                  stall_timeout;
`endif

  modport master (
    output stallreq, exc_req, exc_pc,
`ifdef PIPE_CTRL_WATCHDOG_EN
    input  stall_timeout,
`endif
    input  stall, flush, new_pc
  );

  modport slave (
    input  stallreq, exc_req, exc_pc,
`ifdef PIPE_CTRL_WATCHDOG_EN
    output stall_timeout,
`endif
    output stall, flush, new_pc
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: thermometer stall mask plus a one-shot exception flush FSM.
// Optional stuck-stall watchdog is compiled in with PIPE_CTRL_WATCHDOG_EN.
module pipe_ctrl #(
  parameter int NUM_STAGES  = 6,
  parameter int PC_W        = 32,
  parameter int STALL_LIMIT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PC_W-1:0]       new_pc_q, new_pc_d;
  logic [NUM_STAGES-1:0] therm;

  if (STALL_LIMIT < 1) begin : g_limit_check
    $error("pipe_ctrl: STALL_LIMIT must be at least 1");
  end

  // A stalled stage must also hold every stage upstream of it.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_therm
    assign therm[gi] = |bus.stallreq[NUM_STAGES-1:gi];
  end

  assign bus.stall  = (rst || (state_q == FLUSH)) ? '0 : therm;
  assign bus.flush  = (state_q == FLUSH);
  assign bus.new_pc = new_pc_q;

  always_comb begin
    state_d  = state_q;
    new_pc_d = new_pc_q;
    case (state_q)
      IDLE: begin
        if (bus.exc_req) begin
          state_d  = FLUSH;
          new_pc_d = bus.exc_pc;
        end
      end
      FLUSH: begin
        state_d = bus.exc_req ? WAIT_REL : IDLE;
      end
      WAIT_REL: begin
        // A level request that stays high must not re-trigger.
        if (!bus.exc_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      new_pc_q <= new_pc_d;
    end
  end

`ifdef PIPE_CTRL_WATCHDOG_EN
  localparam int CNT_W = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Counts on the visible mask, so flush cycles break a stall run.
  always_comb begin
    cnt_d = '0;
    if (|bus.stall) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
    end
    timeout_d = timeout_q | (cnt_d == LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.stall_timeout = timeout_q;
`endif

endmodule
